// File: rtl/ahb_lite_arbiter.sv
// Two-master AHB-Lite arbiter: one transfer at a time, IDLE -> ADDR -> DATA, data-phase timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise M0 has fixed priority.
module ahb_lite_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic        write0,
    input  logic        write1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2
    } state_e;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
    localparam logic [1:0] HtransIdle = 2'b00;
    localparam logic [1:0] HtransNonseq = 2'b10;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic        tie_winner;
    logic        winner;
    logic [7:0]  wait_inc;
    logic        wait_expire;

    // Counter saturates instead of wrapping.
    assign wait_inc    = (wait_cnt_q == 8'hff) ? wait_cnt_q : wait_cnt_q + 8'd1;
    assign wait_expire = ~HREADY && (wait_inc == TimeoutCnt);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    assign tie_winner = ~last_q;

    always_comb begin
        last_d = last_q;
        if (state_q == StData && (HREADY || wait_expire)) begin
            last_d = owner_q;
        end
    end

    // Reset to M1 so that M0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign tie_winner = 1'b0;
`endif

    always_comb begin
        if (req0 && req1) begin
            winner = tie_winner;
        end else begin
            winner = req1;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        haddr_d    = haddr_q;
        hwrite_d   = hwrite_q;
        hwdata_d   = hwdata_q;
        wait_cnt_d = wait_cnt_q;
        done0      = 1'b0;
        done1      = 1'b0;
        err0       = 1'b0;
        err1       = 1'b0;
        rdata      = 32'd0;
        HTRANS     = HtransIdle;
        grant      = 2'b00;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    owner_d    = winner;
                    haddr_d    = winner ? addr1 : addr0;
                    hwrite_d   = winner ? write1 : write0;
                    hwdata_d   = winner ? wdata1 : wdata0;
                    wait_cnt_d = 8'd0;
                    state_d    = StAddr;
                end
            end
            StAddr: begin
                HTRANS  = HtransNonseq;
                grant   = owner_q ? 2'b10 : 2'b01;
                state_d = StData;
            end
            StData: begin
                grant = owner_q ? 2'b10 : 2'b01;
                if (HREADY) begin
                    done0   = ~owner_q;
                    done1   = owner_q;
                    rdata   = HRDATA;
                    state_d = StIdle;
                end else begin
                    wait_cnt_d = wait_inc;
                    if (wait_expire) begin
                        err0    = ~owner_q;
                        err1    = owner_q;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Address and write data hold their last latched values between transfers.
    assign HADDR  = haddr_q;
    assign HWRITE = hwrite_q;
    assign HWDATA = hwdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            haddr_q    <= 32'd0;
            hwrite_q   <= 1'b0;
            hwdata_q   <= 32'd0;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            haddr_q    <= haddr_d;
            hwrite_q   <= hwrite_d;
            hwdata_q   <= hwdata_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule
